// File: rtl/mc_control_fsm_if.sv
// Multicycle control FSM bundle: instruction
// fields and status in, datapath controls out.
interface mc_control_fsm_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       ir_write;
    logic       mem_write;
    logic       mem_read;
    logic       reg_write;
    logic       pc_en;
    logic       iord;
    logic       alu_src_a;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_control;
    logic       illegal;
    logic       retire;
    logic [3:0] state;

    modport master (
        output op, funct, zero, mem_ready,
        input  ir_write, mem_write, mem_read,
        input  reg_write, pc_en, iord, alu_src_a,
        input  reg_dst, mem_to_reg, alu_src_b,
        input  pc_src, alu_control, illegal,
        input  retire, state
    );

    modport slave (
        input  op, funct, zero, mem_ready,
        output ir_write, mem_write, mem_read,
        output reg_write, pc_en, iord, alu_src_a,
        output reg_dst, mem_to_reg, alu_src_b,
        output pc_src, alu_control, illegal,
        output retire, state
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-style control FSM with optional
// extended ops, memory stalls and illegal trap.
module mc_control_fsm #(
    parameter int EXT_OPS      = 1,
    parameter int WAIT_MEM     = 0,
    parameter int ILLEGAL_TRAP = 0
) (
    input logic           clk,
    input logic           reset_n,
    mc_control_fsm_if.slave bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11,
        S_HALT     = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BNE  = 6'b000101;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic EXT  = (EXT_OPS != 0);
    localparam logic TRAP = (ILLEGAL_TRAP != 0);

    state_t     r_state;
    state_t     w_next;
    logic       r_illegal;
    logic       w_illegal_next;

    logic       w_is_lw, w_is_sw, w_is_r, w_is_beq;
    logic       w_is_bne, w_is_addi, w_is_j;
    logic       w_funct_ok, w_legal, w_mem_ok;
    logic [2:0] w_alu_r;

    logic       w_ir_write, w_mem_write, w_mem_read;
    logic       w_reg_write, w_pc_write, w_branch_take;
    logic       w_iord, w_alu_src_a, w_reg_dst;
    logic       w_mem_to_reg, w_retire;
    logic [1:0] w_alu_src_b, w_pc_src;
    logic [2:0] w_alu_control;

    assign w_is_lw   = (bus.op == OP_LW);
    assign w_is_sw   = (bus.op == OP_SW);
    assign w_is_r    = (bus.op == OP_R);
    assign w_is_beq  = (bus.op == OP_BEQ);
    assign w_is_bne  = EXT && (bus.op == OP_BNE);
    assign w_is_addi = EXT && (bus.op == OP_ADDI);
    assign w_is_j    = EXT && (bus.op == OP_J);

    assign w_legal = w_is_lw | w_is_sw
                   | (w_is_r & w_funct_ok)
                   | w_is_beq | w_is_bne
                   | w_is_addi | w_is_j;

    // Stalls only exist when memory handshake is on
    assign w_mem_ok = (WAIT_MEM == 0) || bus.mem_ready;

    // R-type funct to ALU operation, flag unknowns
    always_comb begin
        w_funct_ok = 1'b1;
        w_alu_r    = ALU_ADD;
        case (bus.funct)
            6'b100000: w_alu_r = ALU_ADD;
            6'b100010: w_alu_r = ALU_SUB;
            6'b100100: w_alu_r = ALU_AND;
            6'b100101: w_alu_r = ALU_OR;
            6'b101010: w_alu_r = ALU_SLT;
            default:   w_funct_ok = 1'b0;
        endcase
    end

    // State and illegal flag registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_illegal <= w_illegal_next;
        end
    end

    // Next state and per-state control outputs
    always_comb begin
        w_next         = r_state;
        w_illegal_next = 1'b0;
        w_ir_write     = 1'b0;
        w_mem_write    = 1'b0;
        w_mem_read     = 1'b0;
        w_reg_write    = 1'b0;
        w_pc_write     = 1'b0;
        w_branch_take  = 1'b0;
        w_iord         = 1'b0;
        w_alu_src_a    = 1'b0;
        w_reg_dst      = 1'b0;
        w_mem_to_reg   = 1'b0;
        w_retire       = 1'b0;
        w_alu_src_b    = 2'b00;
        w_pc_src       = 2'b00;
        w_alu_control  = ALU_AND;
        case (r_state)
            S_FETCH: begin
                w_mem_read    = 1'b1;
                w_alu_src_b   = 2'b01;
                w_alu_control = ALU_ADD;
                if (w_mem_ok) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end
            end
            S_DECODE: begin
                w_alu_src_b   = 2'b11;
                w_alu_control = ALU_ADD;
                if (!w_legal) begin
                    w_illegal_next = 1'b1;
                    w_retire       = !TRAP;
                    w_next = TRAP ? S_HALT : S_FETCH;
                end else begin
                    unique case (1'b1)
                        w_is_lw, w_is_sw:
                            w_next = S_MEMADR;
                        w_is_r:
                            w_next = S_EXECUTE;
                        w_is_beq, w_is_bne:
                            w_next = S_BRANCH;
                        w_is_addi:
                            w_next = S_ADDIEXEC;
                        w_is_j:
                            w_next = S_JUMP;
                        default:
                            w_next = S_FETCH;
                    endcase
                end
            end
            S_MEMADR, S_ADDIEXEC: begin
                w_alu_src_a   = 1'b1;
                w_alu_src_b   = 2'b10;
                w_alu_control = ALU_ADD;
                if (r_state == S_ADDIEXEC)
                    w_next = S_ADDIWB;
                else if (w_is_lw)
                    w_next = S_MEMREAD;
                else
                    w_next = S_MEMWRITE;
            end
            S_MEMREAD: begin
                w_mem_read = 1'b1;
                w_iord     = 1'b1;
                if (w_mem_ok)
                    w_next = S_MEMWB;
            end
            S_MEMWB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
                w_retire     = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEMWRITE: begin
                w_mem_write = 1'b1;
                w_iord      = 1'b1;
                if (w_mem_ok) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_EXECUTE: begin
                w_alu_src_a   = 1'b1;
                w_alu_control = w_alu_r;
                w_next        = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_reg_dst   = 1'b1;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                w_alu_src_a   = 1'b1;
                w_alu_control = ALU_SUB;
                w_pc_src      = 2'b01;
                w_retire      = 1'b1;
                w_branch_take = (w_is_beq & bus.zero)
                              | (w_is_bne & ~bus.zero);
                w_next        = S_FETCH;
            end
            S_ADDIWB: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_JUMP: begin
                w_pc_src   = 2'b10;
                w_pc_write = 1'b1;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_HALT: begin
                w_illegal_next = 1'b1;
                w_next         = S_HALT;
            end
            default: begin
                w_illegal_next = 1'b1;
                w_next         = S_FETCH;
            end
        endcase
        // Reset shows FETCH controls with writes blocked
        if (!reset_n) begin
            w_ir_write    = 1'b0;
            w_mem_write   = 1'b0;
            w_reg_write   = 1'b0;
            w_pc_write    = 1'b0;
            w_branch_take = 1'b0;
            w_mem_read    = 1'b1;
            w_iord        = 1'b0;
            w_alu_src_a   = 1'b0;
            w_reg_dst     = 1'b0;
            w_mem_to_reg  = 1'b0;
            w_retire      = 1'b0;
            w_alu_src_b   = 2'b01;
            w_pc_src      = 2'b00;
            w_alu_control = ALU_ADD;
        end
    end

    assign bus.ir_write    = w_ir_write;
    assign bus.mem_write   = w_mem_write;
    assign bus.mem_read    = w_mem_read;
    assign bus.reg_write   = w_reg_write;
    assign bus.pc_en       = w_pc_write | w_branch_take;
    assign bus.iord        = w_iord;
    assign bus.alu_src_a   = w_alu_src_a;
    assign bus.reg_dst     = w_reg_dst;
    assign bus.mem_to_reg  = w_mem_to_reg;
    assign bus.alu_src_b   = w_alu_src_b;
    assign bus.pc_src      = w_pc_src;
    assign bus.alu_control = w_alu_control;
    assign bus.retire      = w_retire;
    assign bus.illegal     = reset_n & r_illegal;
    assign bus.state       = reset_n ? r_state : S_FETCH;
endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: four configurations,
// directed literal cases then random instructions.
module tb_mc_control_fsm;
    localparam int NDUT = 4;
    localparam logic [3:0] EXT_V  = 4'b0111;
    localparam logic [3:0] WAIT_V = 4'b0110;
    localparam logic [3:0] TRAP_V = 4'b0100;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] BNE  = 6'b000101;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] JMP  = 6'b000010;

    typedef struct packed {
        logic       ir_write;
        logic       mem_write;
        logic       mem_read;
        logic       reg_write;
        logic       pc_en;
        logic       iord;
        logic       alu_src_a;
        logic       reg_dst;
        logic       mem_to_reg;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [2:0] alu_control;
        logic       illegal;
        logic       retire;
        logic [3:0] state;
    } out_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op_a  [NDUT];
    logic [5:0] fn_a  [NDUT];
    logic       zero_a[NDUT];
    logic       rdy_a [NDUT];
    out_t       out_a [NDUT];

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        mc_control_fsm_if bus ();
        assign bus.op        = op_a[g];
        assign bus.funct     = fn_a[g];
        assign bus.zero      = zero_a[g];
        assign bus.mem_ready = rdy_a[g];
        assign out_a[g] = {bus.ir_write, bus.mem_write,
            bus.mem_read, bus.reg_write, bus.pc_en,
            bus.iord, bus.alu_src_a, bus.reg_dst,
            bus.mem_to_reg, bus.alu_src_b, bus.pc_src,
            bus.alu_control, bus.illegal, bus.retire,
            bus.state};
        mc_control_fsm #(
            .EXT_OPS     (EXT_V[g]  ? 1 : 0),
            .WAIT_MEM    (WAIT_V[g] ? 1 : 0),
            .ILLEGAL_TRAP(TRAP_V[g] ? 1 : 0)
        ) u_dut (
            .clk    (clk),
            .reset_n(rst_n),
            .bus    (bus)
        );
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d",
                     name, act, exp);
        end
    endtask

    // Architectural legality of an instruction
    function automatic bit legal_f(bit ext,
                                   logic [5:0] op,
                                   logic [5:0] fn);
        case (op)
            RT: return fn == 6'b100000 ||
                       fn == 6'b100010 ||
                       fn == 6'b100100 ||
                       fn == 6'b100101 ||
                       fn == 6'b101010;
            LW, SW, BEQ: return 1'b1;
            ADDI, JMP, BNE: return ext;
            default: return 1'b0;
        endcase
    endfunction

    // Step list of one instruction: {count, s4..s0}
    function automatic logic [23:0] plan_f(
        bit ext, bit trap, logic [5:0] op, logic [5:0] fn);
        if (!legal_f(ext, op, fn))
            return trap ? {4'd3, 8'd0, 4'd12, 4'd1, 4'd0}
                        : {4'd2, 12'd0, 4'd1, 4'd0};
        case (op)
            LW:   return {4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
            SW:   return {4'd4, 4'd0, 4'd5, 4'd2, 4'd1, 4'd0};
            RT:   return {4'd4, 4'd0, 4'd7, 4'd6, 4'd1, 4'd0};
            ADDI: return {4'd4, 4'd0, 4'd10, 4'd9, 4'd1, 4'd0};
            JMP:  return {4'd3, 8'd0, 4'd11, 4'd1, 4'd0};
            default:
                  return {4'd3, 8'd0, 4'd8, 4'd1, 4'd0};
        endcase
    endfunction

    function automatic logic [2:0] alu_f(logic [5:0] fn);
        case (fn)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected outputs for a step under given inputs
    function automatic out_t exp_out(
        bit wt, int step, logic [5:0] op, logic [5:0] fn,
        bit z, bit rdy, bit rst, bit ill, bit ret);
        out_t o;
        bit   go;
        o  = '0;
        go = !wt || rdy;
        if (!rst) begin
            o.mem_read    = 1'b1;
            o.alu_src_b   = 2'b01;
            o.alu_control = 3'b010;
            return o;
        end
        o.state   = step[3:0];
        o.illegal = ill;
        o.retire  = ret;
        case (step)
            0: begin
                o.mem_read    = 1'b1;
                o.alu_src_b   = 2'b01;
                o.alu_control = 3'b010;
                o.ir_write    = go;
                o.pc_en       = go;
            end
            1: begin
                o.alu_src_b   = 2'b11;
                o.alu_control = 3'b010;
            end
            2, 9: begin
                o.alu_src_a   = 1'b1;
                o.alu_src_b   = 2'b10;
                o.alu_control = 3'b010;
            end
            3: begin
                o.mem_read = 1'b1;
                o.iord     = 1'b1;
            end
            4: begin
                o.reg_write  = 1'b1;
                o.mem_to_reg = 1'b1;
            end
            5: begin
                o.mem_write = 1'b1;
                o.iord      = 1'b1;
            end
            6: begin
                o.alu_src_a   = 1'b1;
                o.alu_control = alu_f(fn);
            end
            7: begin
                o.reg_write = 1'b1;
                o.reg_dst   = 1'b1;
            end
            8: begin
                o.alu_src_a   = 1'b1;
                o.alu_control = 3'b110;
                o.pc_src      = 2'b01;
                o.pc_en = (op == BEQ && z) ||
                          (op == BNE && !z);
            end
            10: o.reg_write = 1'b1;
            11: begin
                o.pc_src = 2'b10;
                o.pc_en  = 1'b1;
            end
            default: ;
        endcase
        return o;
    endfunction

    logic [23:0] m_plan[NDUT];
    int          m_pos [NDUT];
    bit          m_ill [NDUT];
    logic [5:0]  m_op  [NDUT];
    logic [5:0]  m_fn  [NDUT];

    task automatic new_instr(int g);
        int cls;
        cls = $urandom_range(0, 9);
        m_fn[g] = 6'b100000 + 6'($urandom_range(0, 10));
        case (cls)
            0: m_op[g] = LW;
            1: m_op[g] = SW;
            2, 3: m_op[g] = RT;
            4: m_op[g] = BEQ;
            5: m_op[g] = BNE;
            6: m_op[g] = ADDI;
            7: m_op[g] = JMP;
            8: begin
                m_op[g] = RT;
                m_fn[g] = 6'($urandom_range(0, 63));
            end
            default: m_op[g] = 6'($urandom_range(0, 63));
        endcase
        m_plan[g] = plan_f(EXT_V[g], TRAP_V[g],
                           m_op[g], m_fn[g]);
        m_pos[g] = 0;
    endtask

    task automatic drive(bit r, logic [5:0] o,
                         logic [5:0] f, bit z, bit rdy);
        @(posedge clk);
        #1;
        rst_n = r;
        for (int g = 0; g < NDUT; g++) begin
            op_a[g]   = o;
            fn_a[g]   = f;
            zero_a[g] = z;
            rdy_a[g]  = rdy;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(1'b0, RT, 6'd0, 1'b0, 1'b1);
        drive(1'b0, RT, 6'd0, 1'b0, 1'b1);
    endtask

    initial begin
        int   mw;
        int   rcnt;
        int   step;
        int   n;
        bit   adv;
        bit   ret;
        bit   bad;
        out_t e;

        for (int g = 0; g < NDUT; g++) begin
            op_a[g]   = RT;
            fn_a[g]   = 6'd0;
            zero_a[g] = 1'b0;
            rdy_a[g]  = 1'b1;
        end

        do_reset();
        chk("rst_state", out_a[0].state, 0);
        chk("rst_wen", out_a[0].ir_write +
            out_a[0].pc_en + out_a[0].reg_write, 0);
        chk("rst_mem_read", out_a[0].mem_read, 1);

        rcnt = 0;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, LW, 6'd0, 1'b0, 1'b1);
            chk("lw_state", out_a[0].state, k);
            chk("lw_regwr", out_a[0].reg_write, k == 4);
            chk("lw_m2r", out_a[0].mem_to_reg, k == 4);
            rcnt += out_a[0].retire;
        end
        chk("lw_retires", rcnt, 1);

        for (int t = 0; t < 3; t++) begin
            for (int k = 0; k < 3; k++) begin
                drive(1'b1, t == 0 ? BEQ : BNE, 6'd0,
                      t != 2, 1'b1);
                if (k == 0)
                    chk("br_start", out_a[0].state, 0);
                if (k == 2) begin
                    chk("br_state", out_a[0].state, 8);
                    chk("br_pc_en", out_a[0].pc_en, t != 1);
                end
            end
        end

        for (int k = 0; k < 4; k++) begin
            drive(1'b1, RT, 6'b100010, 1'b0, 1'b1);
            if (k == 2)
                chk("sub_alu", out_a[0].alu_control, 6);
        end

        do_reset();
        mw = 0;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, SW, 6'd0, 1'b0, !(k >= 3 && k <= 5));
            mw += out_a[1].mem_write;
            if (k >= 3 && k <= 6)
                chk("sw_retire", out_a[1].retire, k == 6);
            if (k == 7)
                chk("sw_done", out_a[1].state, 0);
        end
        chk("sw_memwr_cycles", mw, 4);

        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, RT, 6'b000111, 1'b0, 1'b1);
            if (k == 1)
                chk("ill_retire", out_a[0].retire, 1);
            if (k == 2) begin
                chk("ill_st0", out_a[0].state, 0);
                chk("ill_fl0", out_a[0].illegal, 1);
                chk("trap_st", out_a[2].state, 12);
                chk("trap_pc", out_a[2].pc_en, 0);
            end
            if (k == 3) begin
                chk("ill_clr", out_a[0].illegal, 0);
                chk("trap_hold", out_a[2].state, 12);
            end
            if (k >= 2)
                chk("trap_fl", out_a[2].illegal, 1);
        end

        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, ADDI, 6'd0, 1'b0, 1'b1);
            if (k == 2) begin
                chk("noext_st", out_a[3].state, 0);
                chk("noext_ill", out_a[3].illegal, 1);
                chk("addi_st", out_a[0].state, 9);
            end
        end

        do_reset();
        for (int k = 0; k < 7; k++) begin
            drive(k != 5, LW, 6'd0, 1'b0, k < 3);
            if (k == 4) begin
                chk("stall_st", out_a[1].state, 3);
                chk("stall_rd", out_a[1].mem_read, 1);
            end
            if (k == 5)
                chk("rst_stall_wen", out_a[1].ir_write +
                    out_a[1].mem_write + out_a[1].reg_write +
                    out_a[1].pc_en, 0);
            if (k == 6)
                chk("rst_stall_st", out_a[1].state, 0);
        end

        for (int g = 0; g < NDUT; g++) begin
            new_instr(g);
            m_ill[g] = 1'b0;
        end
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            rst_n = (c < 2) ? 1'b0
                  : ($urandom_range(0, 59) != 0);
            for (int g = 0; g < NDUT; g++) begin
                op_a[g]   = m_op[g];
                fn_a[g]   = m_fn[g];
                zero_a[g] = 1'($urandom_range(0, 1));
                rdy_a[g]  = ($urandom_range(0, 2) != 0);
            end
            @(negedge clk);
            for (int g = 0; g < NDUT; g++) begin
                step = int'(m_plan[g][m_pos[g]*4 +: 4]);
                n    = int'(m_plan[g][23:20]);
                if (WAIT_V[g] &&
                    (step == 0 || step == 3 || step == 5))
                    adv = rdy_a[g];
                else
                    adv = (step != 12);
                ret = (m_pos[g] == n - 1) && adv;
                e = exp_out(WAIT_V[g], step, m_op[g],
                            m_fn[g], zero_a[g], rdy_a[g],
                            rst_n, m_ill[g], ret);
                checks++;
                if (out_a[g] !== e) begin
                    fails++;
                    $display("FAIL rand dut%0d cyc%0d: got %h expected %h",
                             g, c, out_a[g], e);
                end
                if (!rst_n) begin
                    m_ill[g] = 1'b0;
                    new_instr(g);
                end else begin
                    bad = !legal_f(EXT_V[g], m_op[g], m_fn[g]);
                    if (step != 12)
                        m_ill[g] = (step == 1) && bad;
                    if (adv) begin
                        m_pos[g]++;
                        if (m_pos[g] == n)
                            new_instr(g);
                    end
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, fails);
        $finish;
    end
endmodule
